// File: rtl/occupancy_ctrl.sv
// Occupancy controller: arbitrates entry/exit sensor edges into inc/dec steps for an external BCD counter.
// Edge-to-command latency 2 cycles; at most one command per 3 cycles; edges that arrive while busy are held pending.
module occupancy_ctrl #(
  parameter logic [7:0] CAP_DEFAULT = 8'h99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ent_req,
  input  logic       ext_req,
  input  logic       cap_ld,
  input  logic [7:0] cap_in,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic       cnt_inc,
  output logic       cnt_dec,
  output logic       cnt_clr_n,
  output logic       ent_grant,
  output logic       ent_deny,
  output logic       ext_grant,
  output logic       ext_err,
  output logic       full,
  output logic       empty,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t     state, state_nxt;
  logic       ent_prev, ext_prev;
  logic       ent_pend, ext_pend;
  logic       ent_rise, ext_rise;
  logic       clr_ent, clr_ext;
  logic       last_ent, last_ent_nxt;
  logic       dir_ext, dir_ext_nxt;
  logic       deny_nxt, err_nxt;
  logic       sel_ext;
  logic [7:0] cap;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign ent_rise = ent_req & ~ent_prev;
  assign ext_rise = ext_req & ~ext_prev;

  assign full  = (bcd1 > cap[7:4]) || ((bcd1 == cap[7:4]) && (bcd0 >= cap[3:0]));
  assign empty = ({bcd1, bcd0} == 8'h00);
  assign busy  = (state != IDLE) || ent_pend || ext_pend;

  assign cnt_inc   = (state == ISSUE) && !dir_ext;
  assign cnt_dec   = (state == ISSUE) &&  dir_ext;
  assign ent_grant = cnt_inc;
  assign ext_grant = cnt_dec;
  assign cnt_clr_n = ~clr;

  always_comb begin
    state_nxt    = state;
    last_ent_nxt = last_ent;
    dir_ext_nxt  = dir_ext;
    clr_ent      = 1'b0;
    clr_ext      = 1'b0;
    deny_nxt     = 1'b0;
    err_nxt      = 1'b0;
    sel_ext      = 1'b0;
    case (state)
      IDLE: begin
        if (ent_pend || ext_pend) begin
          sel_ext = ext_pend && (!ent_pend || last_ent);
          // Round-robin pointer only moves when both sides actually contended.
          if (ent_pend && ext_pend)
            last_ent_nxt = !sel_ext;
          if (sel_ext) begin
            clr_ext = 1'b1;
            if (empty) begin
              err_nxt = 1'b1;
            end else begin
              dir_ext_nxt = 1'b1;
              state_nxt   = ISSUE;
            end
          end else begin
            clr_ent = 1'b1;
            if (full) begin
              deny_nxt = 1'b1;
            end else begin
              dir_ext_nxt = 1'b0;
              state_nxt   = ISSUE;
            end
          end
        end
      end
      ISSUE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Sensor levels are tracked through reset so a level held high yields no edge.
    ent_prev <= ent_req;
    ext_prev <= ext_req;
    if (clr) begin
      state    <= IDLE;
      ent_pend <= 1'b0;
      ext_pend <= 1'b0;
      last_ent <= 1'b0;
      dir_ext  <= 1'b0;
      ent_deny <= 1'b0;
      ext_err  <= 1'b0;
      cap      <= CAP_DEFAULT;
    end else begin
      state    <= state_nxt;
      last_ent <= last_ent_nxt;
      dir_ext  <= dir_ext_nxt;
      ent_deny <= deny_nxt;
      ext_err  <= err_nxt;
      // A rise on an already-pending side is dropped; a clear in the same cycle wins.
      ent_pend <= ent_pend ? ~clr_ent : ent_rise;
      ext_pend <= ext_pend ? ~clr_ext : ext_rise;
      if (cap_ld)
        cap <= {sat9(cap_in[7:4]), sat9(cap_in[3:0])};
    end
  end

endmodule

// File: tb/tb_occupancy_ctrl.sv
// Directed bench for occupancy_ctrl with a behavioural two-digit BCD counter closing the feedback loop.
module tb_occupancy_ctrl;

  logic       clk = 1'b0;
  logic       clr, ent_req, ext_req, cap_ld;
  logic [7:0] cap_in;
  logic [3:0] bcd1, bcd0;
  logic       cnt_inc, cnt_dec, cnt_clr_n, ent_grant, ent_deny, ext_grant, ext_err;
  logic       full, empty, busy;

  logic       ld;
  logic [7:0] ld_val;
  logic [7:0] cnt;
  int         n_inc = 0, n_dec = 0, n_both = 0;
  int         vec_cnt = 0, err_cnt = 0;
  int         snap_inc, snap_dec;

  occupancy_ctrl #(.CAP_DEFAULT(8'h99)) dut (
    .clk(clk), .clr(clr), .ent_req(ent_req), .ext_req(ext_req),
    .cap_ld(cap_ld), .cap_in(cap_in), .bcd1(bcd1), .bcd0(bcd0),
    .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .cnt_clr_n(cnt_clr_n),
    .ent_grant(ent_grant), .ent_deny(ent_deny), .ext_grant(ext_grant), .ext_err(ext_err),
    .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  assign bcd1 = cnt[7:4];
  assign bcd0 = cnt[3:0];

  // Counter model: preload for test setup, clear has priority over steps.
  always @(posedge clk) begin
    if (ld)
      cnt <= ld_val;
    else if (!cnt_clr_n)
      cnt <= 8'h00;
    else if (cnt_inc)
      cnt <= (cnt[3:0] == 4'd9) ? {((cnt[7:4] == 4'd9) ? 4'd0 : cnt[7:4] + 4'd1), 4'd0}
                                : {cnt[7:4], cnt[3:0] + 4'd1};
    else if (cnt_dec)
      cnt <= (cnt[3:0] == 4'd0) ? {((cnt[7:4] == 4'd0) ? 4'd9 : cnt[7:4] - 4'd1), 4'd9}
                                : {cnt[7:4], cnt[3:0] - 4'd1};
    if (cnt_inc) n_inc <= n_inc + 1;
    if (cnt_dec) n_dec <= n_dec + 1;
    if (cnt_inc && cnt_dec) n_both <= n_both + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(1);
  endtask

  task automatic preload(input logic [7:0] v);
    ld = 1'b1; ld_val = v;
    tick(1);
    ld = 1'b0;
  endtask

  task automatic load_cap(input logic [7:0] v);
    cap_in = v; cap_ld = 1'b1;
    tick(1);
    cap_ld = 1'b0;
  endtask

  task automatic entry();
    ent_req = 1'b1;
    tick(1);
    ent_req = 1'b0;
    tick(4);
  endtask

  initial begin
    clr = 1'b1; ent_req = 1'b0; ext_req = 1'b0; cap_ld = 1'b0; cap_in = 8'h00;
    ld = 1'b0; ld_val = 8'h00; cnt = 8'h55;
    tick(2);
    check("rst_clr_n", cnt_clr_n, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd", {cnt_inc, cnt_dec, ent_deny, ext_err}, 4'b0000);
    check("rst_count", cnt, 8'h00);
    check("rst_empty_full", {empty, full}, 2'b10);
    clr = 1'b0;
    tick(1);
    check("clr_n_release", cnt_clr_n, 1'b1);

    // Single entry: command at t+2, idle by t+4
    ent_req = 1'b1;
    tick(1);
    check("ent_t1_inc", cnt_inc, 1'b0);
    check("ent_t1_busy", busy, 1'b1);
    ent_req = 1'b0;
    tick(1);
    check("ent_t2_cmd", {cnt_inc, ent_grant, cnt_dec}, 3'b110);
    tick(1);
    check("ent_t3_count", cnt, 8'h01);
    check("ent_t3_inc", cnt_inc, 1'b0);
    tick(1);
    check("ent_t4_busy", busy, 1'b0);

    // Exit at empty
    do_reset();
    snap_dec = n_dec;
    ext_req = 1'b1;
    tick(1);
    ext_req = 1'b0;
    tick(1);
    check("err_pulse", {ext_err, cnt_dec, ext_grant}, 3'b100);
    tick(1);
    check("err_one_cycle", ext_err, 1'b0);
    tick(2);
    check("err_no_dec", n_dec - snap_dec, 0);
    check("err_count", cnt, 8'h00);

    // Capacity 3: three grants then a deny
    do_reset();
    load_cap(8'h03);
    snap_inc = n_inc;
    entry(); entry(); entry();
    check("cap3_count", cnt, 8'h03);
    check("cap3_full", full, 1'b1);
    ent_req = 1'b1;
    tick(1);
    ent_req = 1'b0;
    tick(1);
    check("cap3_deny", {ent_deny, cnt_inc, ent_grant}, 3'b100);
    tick(3);
    check("cap3_incs", n_inc - snap_inc, 3);
    check("cap3_hold", cnt, 8'h03);

    // Simultaneous pairs at count 05
    do_reset();
    preload(8'h05);
    ent_req = 1'b1; ext_req = 1'b1;
    tick(1);
    ent_req = 1'b0; ext_req = 1'b0;
    tick(1);
    check("pair1_first", {cnt_inc, cnt_dec}, 2'b10);
    tick(1);
    check("pair1_cnt06", cnt, 8'h06);
    tick(2);
    check("pair1_second", {cnt_dec, ext_grant, cnt_inc}, 3'b110);
    tick(1);
    check("pair1_cnt05", cnt, 8'h05);
    tick(1);
    check("pair1_idle", busy, 1'b0);
    ent_req = 1'b1; ext_req = 1'b1;
    tick(1);
    ent_req = 1'b0; ext_req = 1'b0;
    tick(1);
    check("pair2_first", {cnt_inc, cnt_dec}, 2'b01);
    tick(1);
    check("pair2_cnt04", cnt, 8'h04);
    tick(2);
    check("pair2_second", {cnt_inc, cnt_dec}, 2'b10);
    tick(1);
    check("pair2_cnt05", cnt, 8'h05);

    // Sensor held high through reset
    ent_req = 1'b1;
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    snap_inc = n_inc;
    tick(4);
    check("held_no_inc", n_inc - snap_inc, 0);
    check("held_idle", busy, 1'b0);
    check("held_count", cnt, 8'h00);
    ent_req = 1'b0;
    tick(1);

    // Reset during ISSUE
    preload(8'h05);
    ent_req = 1'b1;
    tick(1);
    ent_req = 1'b0;
    tick(1);
    check("abort_in_issue", cnt_inc, 1'b1);
    clr = 1'b1;
    tick(1);
    check("abort_clr_n", cnt_clr_n, 1'b0);
    check("abort_count", cnt, 8'h00);
    check("abort_idle", {busy, cnt_inc, cnt_dec}, 3'b000);
    snap_inc = n_inc; snap_dec = n_dec;
    tick(2);
    clr = 1'b0;
    tick(4);
    check("abort_no_cmd", (n_inc - snap_inc) + (n_dec - snap_dec), 0);
    check("abort_count_after", cnt, 8'h00);

    // Capacity saturation and digit-wise compare
    load_cap(8'hA7);
    preload(8'h97);
    check("cap97_at", full, 1'b1);
    preload(8'h96);
    check("cap97_below", full, 1'b0);
    load_cap(8'h3C);
    preload(8'h39);
    check("cap39_at", full, 1'b1);
    preload(8'h38);
    check("cap39_below", full, 1'b0);
    load_cap(8'h10);
    preload(8'h09);
    check("cap10_cnt09", full, 1'b0);
    preload(8'h10);
    check("cap10_cnt10", full, 1'b1);
    load_cap(8'h00);
    preload(8'h00);
    check("cap00_full", {full, empty}, 2'b11);
    ent_req = 1'b1;
    tick(1);
    ent_req = 1'b0;
    tick(1);
    check("cap00_deny", {ent_deny, cnt_inc}, 2'b10);
    tick(3);

    check("inc_dec_exclusive", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/occupancy_ctrl.md
OCCUPANCY_CTRL -- requirements
Module: occupancy_ctrl

Interface
REQ-001 Parameter: CAP_DEFAULT, 8'h99, BCD capacity loaded on reset.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 clr  in  1  synchronous reset, active-high.
REQ-004 ent_req  in  1  entry sensor level, synchronous to clk.
REQ-005 ext_req  in  1  exit sensor level, synchronous to clk.
REQ-006 cap_ld  in  1  load cap_in into capacity register.
REQ-007 cap_in  in  8  capacity, BCD {tens,units}.
REQ-008 bcd1, bcd0  in  4 each  feedback from the two-digit BCD counter.
REQ-009 cnt_inc, cnt_dec  out  1 each  one-cycle step commands to the counter.
REQ-010 cnt_clr_n  out  1  active-low synchronous clear to the counter.
REQ-011 ent_grant, ent_deny, ext_grant, ext_err  out  1 each  one-cycle result pulses.
REQ-012 full, empty, busy  out  1 each  status levels.

Function
REQ-013 Request edges SHALL be detected by comparing each sensor input with its registered previous value; a rising edge sets that side's pending flag.
REQ-014 A rising edge on a side whose pending flag is already set SHALL be dropped.
REQ-015 The FSM SHALL have states IDLE, ISSUE, SETTLE.
REQ-016 IDLE with no pending flag: stay in IDLE.
REQ-017 IDLE with pending flag(s): select one side. If only one is pending, select it. If both are pending, select the side not served last (round-robin; after reset, entry wins first).
REQ-018 Selected entry while full=1: pulse ent_deny next cycle, clear entry pending, stay in IDLE, issue no counter command.
REQ-019 Selected exit while empty=1: pulse ext_err next cycle, clear exit pending, stay in IDLE, issue no counter command.
REQ-020 Otherwise: clear the selected pending flag, latch the direction, go to ISSUE.
REQ-021 ISSUE (one cycle): cnt_inc=1 and ent_grant=1 for entry, or cnt_dec=1 and ext_grant=1 for exit; next state SETTLE.
REQ-022 SETTLE (one cycle): no commands; lets the counter feedback update; next state IDLE.
REQ-023 Throughput SHALL be at most one counter command per 3 cycles; an edge-to-command latency of 2 cycles when idle.
REQ-024 cnt_inc and cnt_dec SHALL never be high in the same cycle.
REQ-025 cnt_inc and cnt_dec SHALL be decoded from state only.
REQ-026 full = ({bcd1,bcd0} >= capacity), compared as BCD digits (tens first).
REQ-027 empty = ({bcd1,bcd0} == 8'h00).
REQ-028 busy = (state != IDLE) or any pending flag set.
REQ-029 Capacity digits greater than 9 SHALL saturate to 9 on load.
REQ-030 Capacity 00 SHALL make full permanently 1.
REQ-031 cap_ld is accepted in any state and takes effect on the next full evaluation.
REQ-032 Edges arriving during ISSUE or SETTLE SHALL be captured as pending and served afterwards.

Reset
REQ-033 While clr=1: state=IDLE, pending flags=0, round-robin points to entry, capacity=CAP_DEFAULT, all pulse outputs=0, cnt_clr_n=0.
REQ-034 While clr=1, the previous-value registers SHALL load the current sensor levels, so a sensor held high through reset produces no edge.
REQ-035 clr asserted mid-operation (ISSUE or SETTLE) SHALL abort on that edge; no command is issued afterwards and the counter is cleared.
REQ-036 cnt_clr_n SHALL return to 1 in the first cycle after clr deasserts.

Verification
REQ-037 Reset, count=00: single ent_req rise at cycle t -> cnt_inc=1 and ent_grant=1 at t+2, count 01; busy low by t+4.
REQ-038 cap_in=8'h03 loaded; 4 spaced entries -> 3 grants (count 03, full=1), 4th gives ent_deny, no cnt_inc.
REQ-039 count=00: ext_req rise -> ext_err pulse, no cnt_dec, count stays 00.
REQ-040 ent_req and ext_req rise in the same cycle at count 05 -> entry served first (06), exit 3 cycles later (05); next simultaneous pair -> exit served first.
REQ-041 ent_req held high through clr and after it -> no grant; clr asserted during ISSUE -> cnt_clr_n=0, count 00, FSM IDLE, no stray commands.
REQ-042 cap_in=8'hA7 loaded -> capacity 97; count 09 with capacity 10 -> full=0 (BCD comparison, not binary).
